// File: rtl/i2c_pkg.sv
// Shared types and constants for the I2C slave write-receiver.
package i2c_pkg;

  typedef enum logic [2:0] {
    IDLE,
    ADDR,
    ADDR_ACK,
    DATA,
    DATA_ACK,
    IGNORE
  } state_t;

  localparam logic        I2C_RW_WRITE = 1'b0;
  localparam int unsigned BYTE_BITS    = 8;
  localparam int unsigned BIT_CNT_W    = 4;

endpackage

// File: rtl/i2c_line_filter.sv
// Synchroniser plus stability filter for one I2C line, with edge strobes
// derived from the filtered line and its registered copy.
module i2c_line_filter #(
  parameter int unsigned SYNC_STAGES = 2,
  parameter int unsigned FILTER_LEN  = 3
) (
  input  logic clk,
  input  logic reset,
  input  logic raw,
  output logic line,
  output logic rise_c,
  output logic fall_c
);

  localparam int unsigned CNT_W = (FILTER_LEN > 1) ? $clog2(FILTER_LEN + 1) : 1;

  logic [SYNC_STAGES-1:0] sync;
  logic [CNT_W-1:0]       cnt;
  logic                   line_q;
  logic                   sample;

  assign sample = sync[SYNC_STAGES-1];

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sync <= '1;
    end else begin
      sync <= {sync[SYNC_STAGES-2:0], raw};
    end
  end

  // Line only follows the synchronised input after FILTER_LEN agreeing samples.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      line   <= 1'b1;
      line_q <= 1'b1;
      cnt    <= '0;
    end else begin
      line_q <= line;
      if (sample == line) begin
        cnt <= '0;
      end else if (cnt == CNT_W'(FILTER_LEN - 1)) begin
        line <= sample;
        cnt  <= '0;
      end else begin
        cnt <= cnt + CNT_W'(1);
      end
    end
  end

  assign rise_c = line & ~line_q;
  assign fall_c = ~line & line_q;

endmodule

// File: rtl/i2c_slave_rx.sv
// I2C slave write-receiver: address match, ACK/NACK generation and a
// valid/ready-gated byte output; reads are NACKed.
module i2c_slave_rx #(
  parameter logic [6:0]  SLAVE_ADDR  = 7'h50,
  parameter int unsigned SYNC_STAGES = 2,
  parameter int unsigned FILTER_LEN  = 3
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       scl_in,
  input  logic       sda_in,
  output logic       sda_oe,
  output logic [7:0] rx_data,
  output logic       rx_valid,
  output logic       rx_first,
  input  logic       rx_ready,
  output logic       bus_busy,
  output logic       addr_hit
);

  import i2c_pkg::*;

  logic scl_f, scl_rise, scl_fall;
  logic sda_f, sda_rise, sda_fall;
  logic start_c, stop_c;

  state_t                 state;
  logic [BYTE_BITS-1:0]   shreg;
  logic [BIT_CNT_W-1:0]   bit_cnt;
  logic                   first_flag;
  logic                   ack_pend;

  i2c_line_filter #(.SYNC_STAGES(SYNC_STAGES), .FILTER_LEN(FILTER_LEN)) u_scl_filter (
    .clk    (clk),
    .reset  (reset),
    .raw    (scl_in),
    .line   (scl_f),
    .rise_c (scl_rise),
    .fall_c (scl_fall)
  );

  i2c_line_filter #(.SYNC_STAGES(SYNC_STAGES), .FILTER_LEN(FILTER_LEN)) u_sda_filter (
    .clk    (clk),
    .reset  (reset),
    .raw    (sda_in),
    .line   (sda_f),
    .rise_c (sda_rise),
    .fall_c (sda_fall)
  );

  // Any SDA movement while SCL is high is a bus condition, never a data bit.
  assign start_c = sda_fall & scl_f;
  assign stop_c  = sda_rise & scl_f;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state      <= IDLE;
      shreg      <= '0;
      bit_cnt    <= '0;
      first_flag <= 1'b0;
      ack_pend   <= 1'b0;
      sda_oe     <= 1'b0;
      rx_data    <= '0;
      rx_valid   <= 1'b0;
      rx_first   <= 1'b0;
      bus_busy   <= 1'b0;
      addr_hit   <= 1'b0;
    end else begin
      rx_valid <= 1'b0;
      rx_first <= 1'b0;
      if (stop_c) begin
        state    <= IDLE;
        bit_cnt  <= '0;
        ack_pend <= 1'b0;
        sda_oe   <= 1'b0;
        bus_busy <= 1'b0;
        addr_hit <= 1'b0;
      end else if (start_c) begin
        state    <= ADDR;
        bit_cnt  <= '0;
        ack_pend <= 1'b0;
        sda_oe   <= 1'b0;
        bus_busy <= 1'b1;
        addr_hit <= 1'b0;
      end else begin
        case (state)
          ADDR: begin
            if (scl_rise && bit_cnt < BIT_CNT_W'(BYTE_BITS)) begin
              shreg   <= {shreg[BYTE_BITS-2:0], sda_f};
              bit_cnt <= bit_cnt + BIT_CNT_W'(1);
            end else if (scl_fall && bit_cnt == BIT_CNT_W'(BYTE_BITS)) begin
              if (shreg[7:1] == SLAVE_ADDR && shreg[0] == I2C_RW_WRITE) begin
                sda_oe     <= 1'b1;
                addr_hit   <= 1'b1;
                first_flag <= 1'b1;
                state      <= ADDR_ACK;
              end else begin
                sda_oe <= 1'b0;
                state  <= IGNORE;
              end
            end
          end
          ADDR_ACK, DATA_ACK: begin
            if (scl_fall) begin
              sda_oe  <= 1'b0;
              bit_cnt <= '0;
              state   <= DATA;
            end
          end
          DATA: begin
            if (scl_rise && bit_cnt < BIT_CNT_W'(BYTE_BITS)) begin
              shreg   <= {shreg[BYTE_BITS-2:0], sda_f};
              bit_cnt <= bit_cnt + BIT_CNT_W'(1);
            end else if (bit_cnt == BIT_CNT_W'(BYTE_BITS)) begin
              // First cycle at full count decides; the ACK then waits for SCL low.
              if (!ack_pend) begin
                if (rx_ready) begin
                  rx_data    <= shreg;
                  rx_valid   <= 1'b1;
                  rx_first   <= first_flag;
                  first_flag <= 1'b0;
                  ack_pend   <= 1'b1;
                end else begin
                  addr_hit <= 1'b0;
                  state    <= IGNORE;
                end
              end else if (scl_fall) begin
                sda_oe   <= 1'b1;
                ack_pend <= 1'b0;
                state    <= DATA_ACK;
              end
            end
          end
          IGNORE: sda_oe <= 1'b0;
          default: ;
        endcase
      end
    end
  end

endmodule
